// File: rtl/uart_comm_pkg.sv
// uart_comm_pkg: shared types and constants for the uart_comm host serial front end.
package uart_comm_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Bytes per assembled command word
  localparam int CMD_BYTES = 3;

  // 115200 baud from a 100 MHz clock
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 2-flop synchronizer, bit timing and shifter for the receive path.
// Emits a one-cycle rx_rdy with rx_data for every byte whose stop bit is high.
// Optional feature macro: UART_RX_TIMEOUT_EN (adds the rx_busy status output).
module uart_rx
  import uart_comm_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy
`ifdef UART_RX_TIMEOUT_EN
  ,
  output logic       rx_busy
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       sync_reg;
  logic             rx_prev_reg;
  logic             rx_s;
  logic             falling;
  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;

  assign rx_s    = sync_reg[1];
  assign falling = rx_prev_reg & ~rx_s;

  // Synchronize the pin and keep one extra sample for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], rx};
      rx_prev_reg <= sync_reg[1];
    end
  end

  // Receive FSM state, bit timer and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  // Next state: mid-bit sampling, glitch rejection on start, framing check on stop
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    rx_rdy     = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        if (falling) begin
          state_next = RX_START;
          cnt_next   = '0;
        end
      end
      RX_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          if (bit_reg == 3'd7) state_next = RX_STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          state_next = RX_IDLE;
          rx_rdy     = rx_s;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign rx_data = shift_reg;

`ifdef UART_RX_TIMEOUT_EN
  assign rx_busy = (state_reg != RX_IDLE);
`endif

endmodule

// File: rtl/uart_comm.sv
// uart_comm: host-side UART front end. Assembles three received bytes into a
// 24-bit command held until acknowledged, and serializes response bytes.
// Optional feature macro: UART_RX_TIMEOUT_EN (inter-byte timeout on assembly).
module uart_comm
  import uart_comm_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent
);

  if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_param_check
    $error("uart_comm: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [7:0] rx_data;
  logic       rx_rdy;
`ifdef UART_RX_TIMEOUT_EN
  logic       rx_busy;
`endif

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (RX),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy)
`ifdef UART_RX_TIMEOUT_EN
    ,
    .rx_busy (rx_busy)
`endif
  );

  // ---------------- command assembly ----------------
  logic [1:0] byte_cnt_reg, byte_cnt_next;
  logic       cmd_rdy_reg, cmd_rdy_next;
  logic       byte_accept;
  logic       timeout;

  // A pending command blocks new bytes unless the core clears it this cycle
  assign byte_accept = rx_rdy && (!cmd_rdy_reg || clr_cmd_rdy);

  for (genvar gi = 0; gi < CMD_BYTES; gi++) begin : g_slot
    logic [7:0] slot_reg;
    // Capture the received byte into this slot when it is the one being filled
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                          slot_reg <= '0;
      else if (byte_accept && byte_cnt_reg == 2'(gi))      slot_reg <= rx_data;
    end
    assign cmd[8*(CMD_BYTES-1-gi) +: 8] = slot_reg;
  end

  // Byte count and ready flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_reg <= '0;
      cmd_rdy_reg  <= 1'b0;
    end else begin
      byte_cnt_reg <= byte_cnt_next;
      cmd_rdy_reg  <= cmd_rdy_next;
    end
  end

  // Clear first, then let an accepted byte advance the count or complete the command
  always_comb begin
    byte_cnt_next = byte_cnt_reg;
    cmd_rdy_next  = cmd_rdy_reg;
    if (clr_cmd_rdy) cmd_rdy_next = 1'b0;
    if (byte_accept) begin
      if (byte_cnt_reg == 2'(CMD_BYTES - 1)) begin
        byte_cnt_next = '0;
        cmd_rdy_next  = 1'b1;
      end else begin
        byte_cnt_next = byte_cnt_reg + 2'd1;
      end
    end else if (timeout) begin
      byte_cnt_next = '0;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;

  // Inter-byte timer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_reg <= '0;
    else        to_cnt_reg <= to_cnt_next;
  end

  // Runs while a partial command exists, restarts per byte, pauses while a frame is in flight
  always_comb begin
    to_cnt_next = to_cnt_reg;
    timeout     = 1'b0;
    if (byte_accept || byte_cnt_reg == 2'd0) begin
      to_cnt_next = '0;
    end else if (!rx_busy) begin
      if (to_cnt_reg == TO_LAST) begin
        timeout     = 1'b1;
        to_cnt_next = '0;
      end else begin
        to_cnt_next = to_cnt_reg + 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // ---------------- response transmitter ----------------
  tx_state_t        tx_state_reg, tx_state_next;
  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]       tx_bit_reg, tx_bit_next;
  logic [7:0]       tx_shift_reg, tx_shift_next;
  logic             tx_reg, tx_next;
  logic             resp_sent_reg, resp_sent_next;

  // Transmit FSM state and registered line/pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg  <= TX_IDLE;
      tx_cnt_reg    <= '0;
      tx_bit_reg    <= '0;
      tx_shift_reg  <= '0;
      tx_reg        <= 1'b1;
      resp_sent_reg <= 1'b0;
    end else begin
      tx_state_reg  <= tx_state_next;
      tx_cnt_reg    <= tx_cnt_next;
      tx_bit_reg    <= tx_bit_next;
      tx_shift_reg  <= tx_shift_next;
      tx_reg        <= tx_next;
      resp_sent_reg <= resp_sent_next;
    end
  end

  // Start, 8 data bits LSB first, stop; line value is computed one cycle ahead
  always_comb begin
    tx_state_next  = tx_state_reg;
    tx_cnt_next    = tx_cnt_reg;
    tx_bit_next    = tx_bit_reg;
    tx_shift_next  = tx_shift_reg;
    tx_next        = tx_reg;
    resp_sent_next = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        tx_next = 1'b1;
        if (send_resp) begin
          tx_state_next = TX_START;
          tx_shift_next = resp_data;
          tx_cnt_next   = '0;
          tx_next       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_state_next = TX_DATA;
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          tx_next       = tx_shift_reg[0];
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next = '0;
          if (tx_bit_reg == 3'd7) begin
            tx_state_next = TX_STOP;
            tx_next       = 1'b1;
          end else begin
            tx_bit_next   = tx_bit_reg + 3'd1;
            tx_shift_next = {1'b0, tx_shift_reg[7:1]};
            tx_next       = tx_shift_reg[1];
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_state_next  = TX_IDLE;
          tx_cnt_next    = '0;
          resp_sent_next = 1'b1;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      default: begin
        tx_state_next = TX_IDLE;
        tx_next       = 1'b1;
      end
    endcase
  end

  assign TX        = tx_reg;
  assign cmd_rdy   = cmd_rdy_reg;
  assign resp_sent = resp_sent_reg;

endmodule

// File: tb/tb_uart_comm.sv
// tb_uart_comm: directed self-checking bench for uart_comm at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_comm;

  localparam int BIT_CLKS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp_data;
  logic        send_resp;
  logic        resp_sent;

  int n_cmp = 0;
  int n_bad = 0;
  int resp_cnt = 0;

  uart_comm #(
    .CLKS_PER_BIT(BIT_CLKS),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp_data   (resp_data),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (resp_sent) resp_cnt <= resp_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Drive one UART frame on RX (called at a negedge), then a short idle gap
  task automatic uart_tx_byte(input logic [7:0] data, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = frame[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    RX = 1'b1;
    repeat (8) @(negedge clk);
    $display("rx byte %02h stop=%0b sent", data, stop_bit);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    $display("clr_cmd_rdy pulsed");
  endtask

  initial begin
    logic [9:0]  exp_tx;
    logic [23:0] exp_to;
    int          hi_cnt;
    int          hi_cyc;
    int          resp_base;
    logic [7:0]  part;

    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; resp_data = 8'h00; send_resp = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_tx", TX, 1);
    check_val("reset_cmd", cmd, 0);
    check_val("reset_cmd_rdy", cmd_rdy, 0);
    check_val("reset_resp_sent", resp_sent, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic assembly, hold, one-cycle clear latency
    uart_tx_byte(8'h12, 1'b1);
    uart_tx_byte(8'h34, 1'b1);
    check_val("rdy_after_2_bytes", cmd_rdy, 0);
    uart_tx_byte(8'h56, 1'b1);
    check_val("cmd_123456", cmd, 24'h123456);
    check_val("rdy_set", cmd_rdy, 1);
    repeat (50) @(negedge clk);
    check_val("rdy_held", cmd_rdy, 1);
    check_val("cmd_held", cmd, 24'h123456);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check_val("rdy_fell_1cyc", cmd_rdy, 0);
    @(negedge clk);

    // Byte dropped while pending; clear without pending has no effect
    uart_tx_byte(8'h77, 1'b1);
    uart_tx_byte(8'h88, 1'b1);
    uart_tx_byte(8'h99, 1'b1);
    check_val("cmd_778899", cmd, 24'h778899);
    uart_tx_byte(8'hAA, 1'b1);
    check_val("cmd_frozen", cmd, 24'h778899);
    check_val("rdy_still_set", cmd_rdy, 1);
    pulse_clr();
    uart_tx_byte(8'h01, 1'b1);
    pulse_clr();
    uart_tx_byte(8'h02, 1'b1);
    uart_tx_byte(8'h03, 1'b1);
    check_val("cmd_010203", cmd, 24'h010203);
    check_val("rdy_010203", cmd_rdy, 1);
    pulse_clr();

    // Framing error byte is discarded and not counted
    uart_tx_byte(8'h55, 1'b0);
    uart_tx_byte(8'h11, 1'b1);
    uart_tx_byte(8'h22, 1'b1);
    check_val("rdy_framing_2_bytes", cmd_rdy, 0);
    uart_tx_byte(8'h33, 1'b1);
    check_val("cmd_112233", cmd, 24'h112233);
    pulse_clr();

    // Response transmit: A5 bit pattern, resp_sent timing, ignored second request
    exp_tx = {1'b1, 8'hA5, 1'b0};
    hi_cnt = 0;
    hi_cyc = 0;
    send_resp = 1'b1; resp_data = 8'hA5;
    @(negedge clk);
    send_resp = 1'b0;
    check_val("tx_low_cycle1", TX, 0);
    for (int c = 1; c <= 180; c++) begin
      if (c == 40) begin send_resp = 1'b1; resp_data = 8'h00; end
      if (c == 41) send_resp = 1'b0;
      if (resp_sent) begin hi_cnt++; hi_cyc = c; end
      if ((c % BIT_CLKS) == 8 && c < 10 * BIT_CLKS)
        check_val($sformatf("tx_bit%0d", c / BIT_CLKS), TX, exp_tx[c / BIT_CLKS]);
      @(negedge clk);
    end
    $display("tx byte a5 observed");
    check_val("resp_sent_count", hi_cnt, 1);
    check_val("resp_sent_cycle", hi_cyc, 161);
    check_val("tx_idle_after", TX, 1);

    // Inter-byte gap
`ifdef UART_RX_TIMEOUT_EN
    exp_to = 24'hABCDEF;
`else
    exp_to = 24'h12ABCD;
`endif
    uart_tx_byte(8'h12, 1'b1);
    repeat (400) @(negedge clk);
    uart_tx_byte(8'hAB, 1'b1);
    uart_tx_byte(8'hCD, 1'b1);
    uart_tx_byte(8'hEF, 1'b1);
    check_val("cmd_after_gap", cmd, exp_to);
    check_val("rdy_after_gap", cmd_rdy, 1);
    pulse_clr();

    // Reset mid-RX of byte 1 and mid-TX
    uart_tx_byte(8'h12, 1'b1);
    part = 8'h34;
    RX = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      RX = part[b];
      repeat (BIT_CLKS) @(negedge clk);
    end
    send_resp = 1'b1; resp_data = 8'hA5;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (4) @(negedge clk);
    check_val("tx_low_before_reset", TX, 0);
    resp_base = resp_cnt;
    rst_n = 1'b0;
    #1;
    check_val("reset_mid_tx", TX, 1);
    check_val("reset_mid_cmd_rdy", cmd_rdy, 0);
    check_val("reset_mid_cmd", cmd, 0);
    check_val("reset_mid_resp_sent", resp_sent, 0);
    @(negedge clk);
    RX = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check_val("no_resp_after_reset", resp_cnt - resp_base, 0);
    uart_tx_byte(8'hC3, 1'b1);
    uart_tx_byte(8'h3C, 1'b1);
    uart_tx_byte(8'h7E, 1'b1);
    check_val("cmd_after_reset", cmd, 24'hC33C7E);
    check_val("rdy_after_reset", cmd_rdy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
